// File: rtl/banner_renderer.sv
// Banner pixel stage: frame FSM picks the visible logo, stage 1 addresses the
// sprite ROMs, stage 2 turns the returned row bit into banner_on/banner_sel.
module banner_renderer #(
   parameter int SCALE        = 2,
   parameter int PRESS_SCALE  = 2,
   parameter int LOGO_Y       = 96,
   parameter int PRESS_Y      = 320,
   parameter int BLINK_FRAMES = 30,
   parameter int BOSS_FRAMES  = 120
) (
   input  logic         Clk,
   input  logic         Reset_n,
   input  logic         frame_tick,
   input  logic [2:0]   game_state,
   input  logic [9:0]   DrawX,
   input  logic [9:0]   DrawY,
   output logic [3:0]   logo_addr,
   output logic [2:0]   press_addr,
   input  logic [95:0]  galaga_data,
   input  logic [127:0] gameover_data,
   input  logic [111:0] win_data,
   input  logic [63:0]  boss_data,
   input  logic [54:0]  press_data,
   output logic         banner_on,
   output logic [1:0]   banner_sel
);

   localparam int SH  = $clog2(SCALE);
   localparam int PSH = $clog2(PRESS_SCALE);
   localparam int BKW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam int BSW = (BOSS_FRAMES > 1) ? $clog2(BOSS_FRAMES) : 1;
   localparam logic [9:0] LY  = 10'(LOGO_Y);
   localparam logic [9:0] LH  = 10'(16 * SCALE);
   localparam logic [9:0] PY  = 10'(PRESS_Y);
   localparam logic [9:0] PH  = 10'(5 * PRESS_SCALE);
   localparam logic [9:0] PW  = 10'(55 * PRESS_SCALE);
   localparam logic [9:0] PX0 = 10'(320 - (55 * PRESS_SCALE) / 2);
   localparam logic [BKW-1:0] BLINK_LAST = BKW'(BLINK_FRAMES - 1);
   localparam logic [BSW-1:0] BOSS_LOAD  = BSW'(BOSS_FRAMES - 1);

   typedef enum logic [2:0] {
      S_TITLE, S_PLAY, S_BOSS_SHOW, S_BOSS_DONE, S_OVER, S_WIN
   } state_t;

   state_t         state_q, state_d, gs_st, grp_st, st1_q;
   logic [BKW-1:0] blink_cnt_q, blink_cnt_d;
   logic           blink_ph_q, blink_ph_d;
   logic [BSW-1:0] boss_cnt_q, boss_cnt_d;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q     <= S_TITLE;
         blink_cnt_q <= '0;
         blink_ph_q  <= 1'b1;
         boss_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         blink_cnt_q <= blink_cnt_d;
         blink_ph_q  <= blink_ph_d;
         boss_cnt_q  <= boss_cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      blink_cnt_d = blink_cnt_q;
      blink_ph_d  = blink_ph_q;
      boss_cnt_d  = boss_cnt_q;
      case (game_state)
         3'd0:    gs_st = S_TITLE;
         3'd2:    gs_st = S_BOSS_SHOW;
         3'd3:    gs_st = S_OVER;
         3'd4:    gs_st = S_WIN;
         default: gs_st = S_PLAY;
      endcase
      // both boss states count as "already in BOSS" so DONE cannot re-arm
      grp_st = (state_q == S_BOSS_DONE) ? S_BOSS_SHOW : state_q;
      if (frame_tick) begin
         if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            blink_ph_d  = ~blink_ph_q;
         end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
         end
         if (gs_st != grp_st) begin
            state_d = gs_st;
            if (gs_st == S_BOSS_SHOW) boss_cnt_d = BOSS_LOAD;
         end else if (state_q == S_BOSS_SHOW) begin
            if (boss_cnt_q == '0) state_d = S_BOSS_DONE;
            else boss_cnt_d = boss_cnt_q - 1'b1;
         end
      end
   end

   logic [9:0] logo_w, logo_ws, lx0, dx, dy, pdx, pdy;
   logic       logo_hit, press_hit, press_en;

   always_comb begin
      case (state_q)
         S_TITLE:     logo_w = 10'd96;
         S_OVER:      logo_w = 10'd128;
         S_WIN:       logo_w = 10'd112;
         S_BOSS_SHOW: logo_w = 10'd64;
         default:     logo_w = 10'd0;
      endcase
      logo_ws = logo_w << SH;
      lx0     = 10'd320 - (logo_ws >> 1);
      // wrapped differences land far above any box size, so one compare suffices
      dx        = DrawX - lx0;
      dy        = DrawY - LY;
      pdx       = DrawX - PX0;
      pdy       = DrawY - PY;
      logo_hit  = (logo_w != 10'd0) && (dx < logo_ws) && (dy < LH);
      press_en  = blink_ph_q && (state_q == S_TITLE || state_q == S_OVER);
      press_hit = press_en && (pdx < PW) && (pdy < PH);
   end

   logic [3:0] logo_addr_q;
   logic [2:0] press_addr_q;
   logic [6:0] lcol_q;
   logic [5:0] pcol_q;
   logic       lin_q, pin_q;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         logo_addr_q  <= '0;
         press_addr_q <= '0;
         lcol_q       <= '0;
         pcol_q       <= '0;
         lin_q        <= 1'b0;
         pin_q        <= 1'b0;
         st1_q        <= S_TITLE;
      end else begin
         logo_addr_q  <= logo_hit ? 4'(dy >> SH) : 4'd0;
         press_addr_q <= press_hit ? 3'(pdy >> PSH) : 3'd0;
         lcol_q       <= 7'(dx >> SH);
         pcol_q       <= 6'(pdx >> PSH);
         lin_q        <= logo_hit;
         pin_q        <= press_hit;
         st1_q        <= state_q;
      end
   end

   assign logo_addr  = logo_addr_q;
   assign press_addr = press_addr_q;

   logic       lbit, pbit, on_d, on_q;
   logic [1:0] sel_d, sel_q;

   always_comb begin
      lbit = 1'b0;
      case (st1_q)
         S_TITLE:     lbit = galaga_data[7'd95 - lcol_q];
         S_OVER:      lbit = gameover_data[7'd127 - lcol_q];
         S_WIN:       lbit = win_data[7'd111 - lcol_q];
         S_BOSS_SHOW: lbit = boss_data[6'd63 - lcol_q[5:0]];
         default:     lbit = 1'b0;
      endcase
      pbit  = press_data[6'd54 - pcol_q];
      on_d  = 1'b0;
      sel_d = 2'd0;
      if (lin_q) begin
         on_d = lbit;
         if (lbit) sel_d = (st1_q == S_BOSS_SHOW) ? 2'd3 : 2'd1;
      end else if (pin_q && pbit) begin
         on_d  = 1'b1;
         sel_d = 2'd2;
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         on_q  <= 1'b0;
         sel_q <= 2'd0;
      end else begin
         on_q  <= on_d;
         sel_q <= sel_d;
      end
   end

   assign banner_on  = on_q;
   assign banner_sel = sel_q;

endmodule
